// File: rtl/fpaddsub_align_module_if.sv
// Operand/result handshake bundle for the FP add/sub alignment stage.
// slave = the aligner, master = the producer/consumer around it.
interface fpaddsub_align_module_if #(
  parameter int MW    = 26,
  parameter int SW    = 8,
  parameter int TAG_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [MW-1:0]    mant_in;
  logic [SW-1:0]    shift_in;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [MW-1:0]    mant_out;
  logic [TAG_W-1:0] tag_out;
  logic             sat_out;

  modport master (
    output in_valid, mant_in, shift_in, tag_in, out_ready,
    input  in_ready, out_valid, mant_out, tag_out, sat_out
  );

  modport slave (
    input  in_valid, mant_in, shift_in, tag_in, out_ready,
    output in_ready, out_valid, mant_out, tag_out, sat_out
  );
endinterface

// File: rtl/fpaddsub_align_module.sv
// Three-stage mantissa aligner: right shift by exponent difference,
// with every discarded bit folded into a sticky LSB.
module fpaddsub_align_module #(
  parameter int MW    = 26,
  parameter int SW    = 8,
  parameter int TAG_W = 10
) (
  input logic clk,
  input logic rst,
  fpaddsub_align_module_if.slave io
);

  localparam logic [MW-1:0] ONES = '1;

  // Returns {sticky, mant}; sticky picks up bits dropped by this step.
  function automatic logic [MW:0] rsh(
    input logic [MW-1:0] m,
    input logic          s,
    input logic          do_sh,
    input int unsigned   k
  );
    logic [MW-1:0] r;
    logic          st;
    r  = m;
    st = s;
    if (do_sh) begin
      st = st | (|(m & ~(ONES << k)));
      r  = m >> k;
    end
    return {st, r};
  endfunction

  logic             en;
  logic             v1, v2, ov;
  logic [MW-1:0]    m1, m2, mo;
  logic             s1, s2;
  logic [4:0]       a1;
  logic [2:0]       a2;
  logic             q1, q2, qo;
  logic [TAG_W-1:0] t1, t2, to;

  logic             sat_c;
  logic [MW:0]      c2a, c2b;
  logic [MW:0]      c3a, c3b, c3c;

  assign en          = ~ov | io.out_ready;
  assign io.in_ready = en;
  assign io.out_valid = ov;
  assign io.mant_out  = mo;
  assign io.tag_out   = to;
  assign io.sat_out   = qo;

  assign sat_c = 32'(io.shift_in) >= 32'(MW);

  always_comb begin
    c2a = rsh(m1, s1, a1[4], 16);
    c2b = rsh(c2a[MW-1:0], c2a[MW], a1[3], 8);
  end

  always_comb begin
    c3a = rsh(m2, s2, a2[2], 4);
    c3b = rsh(c3a[MW-1:0], c3a[MW], a2[1], 2);
    c3c = rsh(c3b[MW-1:0], c3b[MW], a2[0], 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      m1 <= '0;
      s1 <= 1'b0;
      a1 <= '0;
      q1 <= 1'b0;
      t1 <= '0;
    end else if (en) begin
      v1 <= io.in_valid;
      m1 <= sat_c ? '0 : io.mant_in;
      s1 <= sat_c & (|io.mant_in);
      a1 <= sat_c ? 5'd0 : io.shift_in[4:0];
      q1 <= sat_c;
      t1 <= io.tag_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0;
      m2 <= '0;
      s2 <= 1'b0;
      a2 <= '0;
      q2 <= 1'b0;
      t2 <= '0;
    end else if (en) begin
      v2 <= v1;
      m2 <= c2b[MW-1:0];
      s2 <= c2b[MW];
      a2 <= a1[2:0];
      q2 <= q1;
      t2 <= t1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov <= 1'b0;
      mo <= '0;
      qo <= 1'b0;
      to <= '0;
    end else if (en) begin
      ov <= v2;
      mo <= c3c[MW-1:0] | {{(MW-1){1'b0}}, c3c[MW]};
      qo <= q2;
      to <= t2;
    end
  end

endmodule
